icache: RTL and testbench

ICACHE -- requirements
Module: icache

---
 rtl/cpu_types_pkg.sv | 23 ++
 rtl/icache_frame_array.sv | 42 ++++
 rtl/icache.sv | 129 ++++++++++++
 tb/tb_icache.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types for the instruction cache: FSM state enum, frame record and tag helper.
package cpu_types_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } icache_state_t;

    // Tag field is sized for the narrowest legal index; smaller tags are zero-extended.
    localparam int ICACHE_TAG_MAX_W = 30;

    typedef struct packed {
        logic                        valid;
        logic [ICACHE_TAG_MAX_W-1:0] tag;
        logic [31:0]                 data;
    } icache_frame_t;

    function automatic logic [ICACHE_TAG_MAX_W-1:0] addr_tag(input logic [31:0] addr,
                                                             input int          idx_w);
        return ICACHE_TAG_MAX_W'(addr >> (idx_w + 2));
    endfunction

endpackage

// File: rtl/icache_frame_array.sv
// Direct-mapped frame storage: synchronous write, combinational read, bulk valid clear.
module icache_frame_array
    import cpu_types_pkg::*;
#(
    parameter int SETS  = 16,
    parameter int IDX_W = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             flush_i,
    input  logic             we_i,
    input  logic [IDX_W-1:0] widx_i,
    input  icache_frame_t    wframe_i,
    input  logic [IDX_W-1:0] ridx_i,
    output icache_frame_t    rframe_o
);

    icache_frame_t frames_q [SETS];

    // NOTE: the whole array is cleared on reset so a reset-time read returns zero data,
    // which keeps the frames in flops rather than a RAM macro.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < SETS; i++) begin
                frames_q[i] <= '0;
            end
        end else begin
            if (flush_i) begin
                for (int i = 0; i < SETS; i++) begin
                    frames_q[i].valid <= 1'b0;
                end
            end
            // A fill in the flush cycle arrives with valid=0, so ordering here is harmless.
            if (we_i) begin
                frames_q[widx_i] <= wframe_i;
            end
        end
    end

    assign rframe_o = frames_q[ridx_i];

endmodule

// File: rtl/icache.sv
// Direct-mapped one-word-per-frame instruction cache with fill bypass.
// Optional hit/miss statistics are built when ICACHE_STATS_EN is defined.
module icache
    import cpu_types_pkg::*;
#(
    parameter int SETS  = 16,
    parameter int IDX_W = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    input  logic        flush,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    icache_state_t state_q, state_d;
    logic [29:0]   addr_q, addr_d;
    icache_frame_t rframe, wframe;
    logic          lookup_hit;
    logic          fill_we;
    logic          idle_hit, idle_miss;
    logic          unused_addr_lsb;

    assign unused_addr_lsb = ^imemaddr[1:0];

    icache_frame_array #(
        .SETS  (SETS),
        .IDX_W (IDX_W)
    ) u_frames (
        .CLK      (CLK),
        .RST      (RST),
        .flush_i  (flush),
        .we_i     (fill_we),
        .widx_i   (addr_q[IDX_W-1:0]),
        .wframe_i (wframe),
        .ridx_i   (imemaddr[IDX_W+1:2]),
        .rframe_o (rframe)
    );

    assign lookup_hit = rframe.valid && (rframe.tag == addr_tag(imemaddr, IDX_W));

    // NOTE: every output of this block gets a default first, so no path leaves a
    // signal unassigned and no latch can be inferred.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        ihit      = 1'b0;
        imemload  = '0;
        iREN      = 1'b0;
        iaddr     = '0;
        fill_we   = 1'b0;
        idle_hit  = 1'b0;
        idle_miss = 1'b0;
        wframe    = '{valid: !flush, tag: addr_tag({addr_q, 2'b00}, IDX_W), data: iload};

        case (state_q)
            IDLE: begin
                if (imemREN) begin
                    if (lookup_hit) begin
                        idle_hit = !flush;
                        ihit     = !flush;
                        imemload = flush ? '0 : rframe.data;
                    end else begin
                        idle_miss = 1'b1;
                        addr_d    = imemaddr[31:2];
                        state_d   = FETCH;
                    end
                end
            end
            FETCH: begin
                iREN  = 1'b1;
                iaddr = {addr_q, 2'b00};
                if (!iwait) begin
                    fill_we = 1'b1;
                    state_d = IDLE;
                    // Bypass only if the datapath still wants the word being filled.
                    if (imemREN && (imemaddr[31:2] == addr_q) && !flush) begin
                        ihit     = 1'b1;
                        imemload = iload;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (idle_hit)  hit_cnt_q  <= hit_cnt_q + 32'd1;
            if (idle_miss) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`else
    logic unused_stats;
    assign unused_stats = idle_hit ^ idle_miss;
    assign hit_count    = '0;
    assign miss_count   = '0;
`endif

endmodule

// File: tb/tb_icache.sv
// Directed self-checking bench for icache (default SETS=16, IDX_W=4).
// Statistics expectations follow ICACHE_STATS_EN; without it the counters must read 0.
module tb_icache;

`ifdef ICACHE_STATS_EN
    localparam bit STATS_EN = 1'b1;
`else
    localparam bit STATS_EN = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        flush;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int n_checks = 0;
    int n_errors = 0;

    icache dut (
        .CLK        (CLK),
        .RST        (RST),
        .imemREN    (imemREN),
        .imemaddr   (imemaddr),
        .ihit       (ihit),
        .imemload   (imemload),
        .flush      (flush),
        .iREN       (iREN),
        .iaddr      (iaddr),
        .iwait      (iwait),
        .iload      (iload),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] stat(input logic [31:0] v);
        return v & {32{STATS_EN}};
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Full miss: lookup cycle, nwait busy cycles, then completion with bypass; drops imemREN after.
    task automatic do_miss(input logic [31:0] a, input logic [31:0] d, input int nwait, input string tag);
        imemREN  = 1'b1;
        imemaddr = a;
        iwait    = 1'b1;
        settle();
        check({tag, "_lookup_ihit"}, 32'(ihit), 32'd0);
        check({tag, "_lookup_iren"}, 32'(iREN), 32'd0);
        tick();
        for (int i = 0; i < nwait; i++) begin
            check({tag, "_wait_iren"},  32'(iREN), 32'd1);
            check({tag, "_wait_iaddr"}, iaddr, {a[31:2], 2'b00});
            check({tag, "_wait_ihit"},  32'(ihit), 32'd0);
            tick();
        end
        iwait = 1'b0;
        iload = d;
        settle();
        check({tag, "_done_iren"},  32'(iREN), 32'd1);
        check({tag, "_done_iaddr"}, iaddr, {a[31:2], 2'b00});
        check({tag, "_done_ihit"},  32'(ihit), 32'd1);
        check({tag, "_done_load"},  imemload, d);
        tick();
        iwait   = 1'b1;
        iload   = '0;
        imemREN = 1'b0;
        settle();
    endtask

    initial begin
        RST      = 1'b1;
        imemREN  = 1'b0;
        imemaddr = '0;
        flush    = 1'b0;
        iwait    = 1'b1;
        iload    = '0;
        tick();
        tick();
        RST = 1'b0;
        settle();
        check("rst_ihit",  32'(ihit), 32'd0);
        check("rst_iren",  32'(iREN), 32'd0);
        check("rst_iaddr", iaddr, 32'd0);
        check("rst_load",  imemload, 32'd0);
        check("rst_hits",  hit_count, 32'd0);
        check("rst_miss",  miss_count, 32'd0);

        // Cold miss at 0x40 with three busy cycles: four request cycles, bypass in the last.
        do_miss(32'h0000_0040, 32'h2408_0001, 3, "cold40");
        check("cold40_miss_count", miss_count, stat(32'd1));

        // Repeat read hits combinationally; byte-offset bits ignored.
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0043;
        settle();
        check("hit40_ihit",  32'(ihit), 32'd1);
        check("hit40_load",  imemload, 32'h2408_0001);
        check("hit40_iren",  32'(iREN), 32'd0);
        check("hit40_iaddr", iaddr, 32'd0);
        tick();
        check("hit40_hit_count", hit_count, stat(32'd1));
        imemREN = 1'b0;
        settle();
        check("noreq_ihit", 32'(ihit), 32'd0);
        tick();
        check("noreq_iren", 32'(iREN), 32'd0);

        // 0x80 shares index 0 with 0x40: it evicts 0x40, which then misses again.
        do_miss(32'h0000_0080, 32'hAAAA_0080, 1, "conf80");
        do_miss(32'h0000_0040, 32'h2408_0001, 0, "conf40");
        check("conf_miss_count", miss_count, stat(32'd3));
        check("conf_hit_count",  hit_count,  stat(32'd1));

        // Redirect mid-fetch: fill still lands at 0x100, no bypass for 0x200.
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0100;
        settle();
        check("redir_lookup_ihit", 32'(ihit), 32'd0);
        tick();
        imemaddr = 32'h0000_0200;
        settle();
        check("redir_wait_iaddr", iaddr, 32'h0000_0100);
        tick();
        iwait = 1'b0;
        iload = 32'h1111_0100;
        settle();
        check("redir_done_iren",  32'(iREN), 32'd1);
        check("redir_done_iaddr", iaddr, 32'h0000_0100);
        check("redir_done_ihit",  32'(ihit), 32'd0);
        tick();
        iwait    = 1'b1;
        iload    = '0;
        imemaddr = 32'h0000_0100;
        settle();
        check("redir_100_ihit", 32'(ihit), 32'd1);
        check("redir_100_load", imemload, 32'h1111_0100);
        tick();
        do_miss(32'h0000_0200, 32'h2222_0200, 0, "redir200");
        check("redir_hit_count", hit_count, stat(32'd2));

        // Flush in the completion cycle: no bypass and the line is not left valid.
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0300;
        tick();
        iwait = 1'b0;
        iload = 32'h3333_0300;
        flush = 1'b1;
        settle();
        check("flush_done_iren", 32'(iREN), 32'd1);
        check("flush_done_ihit", 32'(ihit), 32'd0);
        tick();
        flush = 1'b0;
        iwait = 1'b1;
        iload = '0;
        do_miss(32'h0000_0300, 32'h3333_0300, 0, "flush300");
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0300;
        settle();
        check("flush_rehit_ihit", 32'(ihit), 32'd1);
        tick();
        check("flush_miss_count", miss_count, stat(32'd7));
        check("flush_hit_count",  hit_count,  stat(32'd3));

        // Reset during a fetch: fill discarded, request dropped, counters and frames cleared.
        imemaddr = 32'h0000_0044;
        tick();
        check("rstf_fetch_iren", 32'(iREN), 32'd1);
        RST   = 1'b1;
        iwait = 1'b0;
        iload = 32'h4444_4444;
        tick();
        RST     = 1'b0;
        iwait   = 1'b1;
        iload   = '0;
        imemREN = 1'b0;
        settle();
        check("rstf_iren",  32'(iREN), 32'd0);
        check("rstf_iaddr", iaddr, 32'd0);
        check("rstf_ihit",  32'(ihit), 32'd0);
        check("rstf_hits",  hit_count, 32'd0);
        check("rstf_miss",  miss_count, 32'd0);
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0300;
        settle();
        check("rstf_300_ihit", 32'(ihit), 32'd0);
        tick();
        check("rstf_300_iren",  32'(iREN), 32'd1);
        check("rstf_300_iaddr", iaddr, 32'h0000_0300);
        iwait = 1'b0;
        iload = 32'h3030_3030;
        tick();
        iwait    = 1'b1;
        imemaddr = 32'h0000_0044;
        settle();
        check("rstf_44_ihit", 32'(ihit), 32'd0);
        check("rstf_miss_count", miss_count, stat(32'd1));
        tick();
        imemREN = 1'b0;
        iwait   = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
